// File: rtl/toggle_fsm_multi.sv
// Per-channel four-phase toggle tracker (Idle -> Start -> Stop -> Clear -> Idle) with
// hold-time glitch filtering, registered K1/K2 pulses and saturating completed-cycle counters.
module toggle_fsm_multi #(
  parameter int unsigned CH    = 4,
  parameter int unsigned HOLD  = 1,
  parameter int unsigned CNT_W = 8
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  En,
  input  logic [CH-1:0]         A,
  input  logic                  Clr_cnt,
  output logic [CH-1:0]         K1,
  output logic [CH-1:0]         K2,
  output logic [2*CH-1:0]       State,
  output logic [CH*CNT_W-1:0]   Cycle_cnt
);

  localparam int unsigned QW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [QW-1:0]    QMax   = QW'(HOLD - 1);
  localparam logic [CNT_W-1:0] CntMax = '1;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StStart = 2'b01,
    StStop  = 2'b10,
    StClear = 2'b11
  } state_t;

  state_t           r_state [CH];
  logic [QW-1:0]    r_q     [CH];
  logic [CNT_W-1:0] r_cnt   [CH];
  logic [CH-1:0]    r_k1, r_k2;

  state_t           w_state [CH];
  logic [QW-1:0]    w_q     [CH];
  logic [CNT_W-1:0] w_cnt   [CH];
  logic [CH-1:0]    w_k1, w_k2, w_expect;

  always_comb begin
    for (int i = 0; i < CH; i++) begin
      w_state[i]  = r_state[i];
      w_q[i]      = '0;
      w_k1[i]     = 1'b0;
      w_k2[i]     = 1'b0;
      w_cnt[i]    = r_cnt[i];
      // Idle and Stop wait for a high level; Start and Clear wait for a low level.
      w_expect[i] = (r_state[i] == StIdle) || (r_state[i] == StStop);
      if (En && (A[i] == w_expect[i])) begin
        if (r_q[i] == QMax) begin
          unique case (r_state[i])
            StIdle:  w_state[i] = StStart;
            StStart: w_state[i] = StStop;
            StStop: begin
              w_state[i] = StClear;
              w_k2[i]    = 1'b1;
            end
            StClear: begin
              w_state[i] = StIdle;
              w_k1[i]    = 1'b1;
            end
          endcase
        end else begin
          w_q[i] = r_q[i] + QW'(1);
        end
      end
      // Clear wins over a coincident completion, so that completion is lost.
      if (Clr_cnt) begin
        w_cnt[i] = '0;
      end else if (w_k1[i] && (r_cnt[i] != CntMax)) begin
        w_cnt[i] = r_cnt[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      for (int i = 0; i < CH; i++) begin
        r_state[i] <= StIdle;
        r_q[i]     <= '0;
        r_cnt[i]   <= '0;
      end
      r_k1 <= '0;
      r_k2 <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        r_state[i] <= w_state[i];
        r_q[i]     <= w_q[i];
        r_cnt[i]   <= w_cnt[i];
      end
      r_k1 <= w_k1;
      r_k2 <= w_k2;
    end
  end

  always_comb begin
    State     = '0;
    Cycle_cnt = '0;
    for (int i = 0; i < CH; i++) begin
      State[2*i +: 2]          = r_state[i];
      Cycle_cnt[i*CNT_W +: CNT_W] = r_cnt[i];
    end
  end

  assign K1 = r_k1;
  assign K2 = r_k2;

endmodule
